// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO sharing controller
// Contents:
//   DATA_W_DEF  default data width, matches the shared FIFO
//   wr_state_t  write-side arbiter state {IDLE, BURST}
//   rr_pick     round-robin pick: first set bit of valid after ptr, wrapping at n
package fifo_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wr_state_t;

    // Scans ptr+1, ptr+2, ... ptr+n (mod n). Descending loop so the nearest
    // candidate after ptr is the last one assigned and wins. ptr itself is
    // reached last, so it is only chosen when nothing else is valid.
    // Returns ptr when valid is all zero; callers gate on |valid.
    function automatic logic [3:0] rr_pick(input logic [15:0] valid,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic [3:0] pick;
        int         j;
        pick = ptr;
        for (int k = 16; k >= 1; k--) begin
            if (k <= n) begin
                j = (int'(ptr) + k) % n;
                if (valid[j[3:0]]) begin
                    pick = j[3:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// rtl/fifo_out_skid.sv - FIFO read issue plus 2-entry output buffer
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   fifo_rden     out  read enable towards the FIFO
//   fifo_rddata   in   read data, valid one cycle after fifo_rden
//   fifo_empty    in   registered FIFO empty flag
//   out_valid     out  consumer valid (buffer not empty)
//   out_data      out  buffer head, registered
//   out_ready     in   consumer ready
module fifo_out_skid
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              fifo_rden,
    input  logic [DATA_W-1:0] fifo_rddata,
    input  logic              fifo_empty,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic              r_pend;
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic              w_pop;
    logic [2:0]        w_fill;

    assign w_pop  = (r_cnt != 2'd0) && out_ready;
    // Occupancy after this edge including the read already in flight; a new
    // read is only issued if its data is guaranteed a free slot.
    assign w_fill = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign fifo_rden = !fifo_empty && (w_fill < 3'd2);

    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_head;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend <= 1'b0;
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_pend <= fifo_rden;
            case ({r_pend, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= fifo_rddata;
                    end else begin
                        r_tail <= fifo_rddata;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_head <= fifo_rddata;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= fifo_rddata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(r_pend && !w_pop && (r_cnt == 2'd2)));

endmodule

// File: rtl/fifo_share_ctrl.sv
// rtl/fifo_share_ctrl.sv - shares one synchronous FIFO between NUM_REQ producers and one consumer
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/req_data/req_ready  producer streams, data slice i = [i*DATA_W +: DATA_W]
//   fifo_wren/fifo_wrdata      FIFO write port
//   fifo_rden/fifo_rddata      FIFO read port (1-cycle read latency)
//   fifo_full/fifo_empty       registered FIFO flags
//   out_valid/out_data/out_ready  consumer stream
//   grant_id                   current or last granted producer (debug)
module fifo_share_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wren,
    output logic [DATA_W-1:0]         fifo_wrdata,
    output logic                      fifo_rden,
    input  logic [DATA_W-1:0]         fifo_rddata,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    wr_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [IDX_W-1:0] r_ptr,   w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             w_exit;
    logic             w_gnt_valid;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_pick_from;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = r_owner;
        w_exit      = (r_state == BURST) &&
                      (!req_valid[r_owner] || (r_cnt == CNT_W'(MAX_BURST)));
        // On burst exit the pointer moves to the owner in this same cycle, so
        // arbitration already searches from the owner to avoid a bubble.
        w_pick_from = (r_state == BURST) ? r_owner : r_ptr;

        // A full FIFO freezes the whole write side, burst count included.
        if (!fifo_full) begin
            if ((r_state == IDLE) || w_exit) begin
                if (w_exit) begin
                    w_ptr_nxt = r_owner;
                end
                if (|req_valid) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = IDX_W'(rr_pick(16'(req_valid), 4'(w_pick_from), NUM_REQ));
                    w_state_nxt = BURST;
                    w_owner_nxt = w_gnt_idx;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end else begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = r_owner;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
        end
    end

    assign req_ready   = w_gnt_valid ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign fifo_wren   = |(req_valid & req_ready);
    assign fifo_wrdata = req_data[w_gnt_idx*DATA_W +: DATA_W];
    assign grant_id    = w_gnt_valid ? w_gnt_idx : r_owner;

    fifo_out_skid #(
        .DATA_W(DATA_W)
    ) u_out_skid (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_rden  (fifo_rden),
        .fifo_rddata(fifo_rddata),
        .fifo_empty (fifo_empty),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// tb/tb_fifo_share_ctrl.sv - self-checking bench for fifo_share_ctrl with a behavioural FIFO
module tb_fifo_share_ctrl;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            fifo_wren, fifo_rden, fifo_full, fifo_empty;
    logic [DW-1:0]   fifo_wrdata, fifo_rddata, out_data;
    logic            out_valid, out_ready;
    logic [1:0]      grant_id;
    logic            force_full = 1'b0;
    logic            hold_empty = 1'b0;

    always #5 clk = ~clk;

    fifo_share_ctrl #(.DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
        .fifo_rden(fifo_rden), .fifo_rddata(fifo_rddata),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .grant_id(grant_id)
    );

    // Behavioural FIFO with registered flags; force_full/hold_empty let the
    // bench stall writes or keep data parked in the FIFO.
    logic [DW-1:0] m_q[$];
    logic          m_full_r, m_empty_r;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            fifo_rddata <= '0;
            m_full_r    <= 1'b0;
            m_empty_r   <= 1'b1;
        end else begin
            if (fifo_rden && (m_q.size() > 0)) fifo_rddata <= m_q.pop_front();
            if (fifo_wren) m_q.push_back(fifo_wrdata);
            m_empty_r <= (m_q.size() == 0);
            m_full_r  <= (m_q.size() >= DEPTH);
        end
    end

    assign fifo_full  = m_full_r | force_full;
    assign fifo_empty = m_empty_r | hold_empty;

    int           n_chk = 0;
    int           n_pass = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pdata[NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later. Consumer
    // pops are scored against exp_q; accepted writes are pushed onto it.
    task automatic step(input logic [3:0] valid, input logic ff, input logic he,
                        input logic ordy, input logic [3:0] exp_rdy, input logic chk_wr);
        int idx;
        @(negedge clk);
        req_valid = valid;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pdata[i];
        force_full = ff;
        hold_empty = he;
        out_ready  = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_extra_pop", 32'(out_valid), 32'd0);
            else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        if (chk_wr) begin
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("wren", 32'(fifo_wren), 32'(exp_rdy != 4'd0));
            if (exp_rdy != 4'd0) begin
                idx = 0;
                for (int i = 0; i < NR; i++) if (exp_rdy[i]) idx = i;
                chk("wrdata", 32'(fifo_wrdata), 32'(pdata[idx]));
                chk("grant_id", 32'(grant_id), 32'(idx));
                exp_q.push_back(pdata[idx]);
                pdata[idx] = pdata[idx] + 8'd1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((exp_q.size() != 0) || out_valid) && (n < 200)) begin
            step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_ov", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       ff;
        logic [3:0] rdy;
    } wr_vec_t;

    wr_vec_t stall_tab[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        pdata[0] = 8'hA5; pdata[1] = 8'h10; pdata[2] = 8'h40; pdata[3] = 8'h70;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wren", 32'(fifo_wren), 32'd0);
        chk("rst_rden", 32'(fifo_rden), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single producer 0 beat granted combinationally
        step(4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1);
        chk("first_wrdata", 32'(fifo_wrdata), 32'h0000_00A5);
        drain();

        @(negedge clk);
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;

        // All producers valid: 0x4, 1x4, 2x4, 3x4, 0 with no gaps
        for (int c = 0; c < 17; c++)
            step(4'b1111, 1'b0, 1'b0, 1'b1, 4'(1 << ((c / MB) % NR)), 1'b1);
        drain();

        // Full for 3 cycles at cnt=2; burst resumes for 2 beats, then rotates
        stall_tab[0] = '{4'b0100, 1'b0, 4'b0100};
        stall_tab[1] = '{4'b0100, 1'b0, 4'b0100};
        stall_tab[2] = '{4'b0110, 1'b1, 4'b0000};
        stall_tab[3] = '{4'b0110, 1'b1, 4'b0000};
        stall_tab[4] = '{4'b0110, 1'b1, 4'b0000};
        stall_tab[5] = '{4'b0110, 1'b0, 4'b0100};
        stall_tab[6] = '{4'b0110, 1'b0, 4'b0100};
        stall_tab[7] = '{4'b0110, 1'b0, 4'b0010};
        for (int i = 0; i < 8; i++)
            step(stall_tab[i].valid, stall_tab[i].ff, 1'b0, 1'b1, stall_tab[i].rdy, 1'b1);
        drain();

        // 5 entries parked in the FIFO, consumer ready
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 8; c++) begin
            step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
            chk("rd5_rden", 32'(fifo_rden), 32'(c < 5));
            chk("rd5_out_valid", 32'(out_valid), 32'((c >= 2) && (c < 7)));
        end
        drain();

        // 5 entries parked, consumer stalled: only 2 reads, head held
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
            chk("stall_rden", 32'(fifo_rden), 32'(c < 2));
            chk("stall_out_valid", 32'(out_valid), 32'(c >= 2));
            if (c >= 2) chk("stall_out_data", 32'(out_data), 32'(exp_q[0]));
        end
        drain();

        // Asynchronous reset with buffered data and a read in flight
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_rden", 32'(fifo_rden), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_wren", 32'(fifo_wren), 32'd0);
        chk("arst_grant_id", 32'(grant_id), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
